// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ALU opcodes and helpers for the pipelined datapath
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;
    localparam int SA_W   = 5;
    localparam int ALUC_W = 4;

    // Link register written by jal
    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef enum logic [ALUC_W-1:0] {
        ALUC_ADD = 4'b0000,
        ALUC_AND = 4'b0001,
        ALUC_XOR = 4'b0010,
        ALUC_SLL = 4'b0011,
        ALUC_SUB = 4'b0100,
        ALUC_OR  = 4'b0101,
        ALUC_LUI = 4'b0110,
        ALUC_SRL = 4'b0111,
        ALUC_SRA = 4'b1111
    } aluc_t;

    // Widen the 16-bit immediate; sign bit is only replicated when sext is set
    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sext);
        return {{(DATA_W-IMM_W){sext & imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - two-level operand forwarding select (EX/MEM over MEM/WB over register file)
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
) (
    input  logic [RW-1:0] src_i,
    input  logic [DW-1:0] reg_i,
    input  logic          m_wreg_i,
    input  logic          m_m2reg_i,
    input  logic [RW-1:0] m_wn_i,
    input  logic [DW-1:0] m_alu_i,
    input  logic          w_wreg_i,
    input  logic [RW-1:0] w_wn_i,
    input  logic [DW-1:0] w_data_i,
    output logic [DW-1:0] val_o
);

    logic src_nz;
    logic hit_mem;
    logic hit_wb;

    // A load in EX/MEM has no data yet, so it never forwards; r0 is hard zero
    always_comb begin
        src_nz  = (src_i != '0);
        hit_mem = m_wreg_i & ~m_m2reg_i & (m_wn_i == src_i) & src_nz;
        hit_wb  = w_wreg_i & (w_wn_i == src_i) & src_nz;
        if (hit_mem) begin
            val_o = m_alu_i;
        end else if (hit_wb) begin
            val_o = w_data_i;
        end else begin
            val_o = reg_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with EX operand forwarding and load-use detection
module ex_operand_stage
    import pipe_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          d_valid,
    input  logic [DW-1:0] d_ra,
    input  logic [DW-1:0] d_rb,
    input  logic [15:0]   d_imm,
    input  logic [4:0]    d_sa,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_wn,
    input  logic [3:0]    d_aluc,
    input  logic          d_wreg,
    input  logic          d_m2reg,
    input  logic          d_wmem,
    input  logic          d_aluimm,
    input  logic          d_shift,
    input  logic          d_sext,
    input  logic          d_jal,
    input  logic [DW-1:0] d_pc4,
    input  logic          m_wreg,
    input  logic          m_m2reg,
    input  logic [RW-1:0] m_wn,
    input  logic [DW-1:0] m_alu,
    input  logic          w_wreg,
    input  logic [RW-1:0] w_wn,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] e_alu_a,
    output logic [DW-1:0] e_alu_b,
    output logic [3:0]    e_aluc,
    output logic [DW-1:0] e_store,
    output logic [RW-1:0] e_wn,
    output logic          e_wreg,
    output logic          e_m2reg,
    output logic          e_wmem,
    output logic          e_jal,
    output logic [DW-1:0] e_pc8,
    output logic          e_valid,
    output logic          e_hazard
);

    logic          valid_q,  valid_d;
    logic [DW-1:0] ra_q,     ra_d;
    logic [DW-1:0] rb_q,     rb_d;
    logic [DW-1:0] imm_q,    imm_d;
    logic [4:0]    sa_q,     sa_d;
    logic [RW-1:0] rs_q,     rs_d;
    logic [RW-1:0] rt_q,     rt_d;
    logic [RW-1:0] wn_q,     wn_d;
    logic [3:0]    aluc_q,   aluc_d;
    logic          wreg_q,   wreg_d;
    logic          m2reg_q,  m2reg_d;
    logic          wmem_q,   wmem_d;
    logic          aluimm_q, aluimm_d;
    logic          shift_q,  shift_d;
    logic          jal_q,    jal_d;
    logic [DW-1:0] pc8_q,    pc8_d;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          rs_used;
    logic          rt_used;

    // Next-state values: immediate extension, link target and pc+8 are resolved before the register
    always_comb begin
        valid_d  = d_valid;
        ra_d     = d_ra;
        rb_d     = d_rb;
        imm_d    = ext_imm(d_imm, d_sext);
        sa_d     = d_sa;
        rs_d     = d_rs;
        rt_d     = d_rt;
        wn_d     = d_jal ? RW'(REG_RA) : d_wn;
        aluc_d   = d_aluc;
        wreg_d   = d_wreg & d_valid;
        m2reg_d  = d_m2reg & d_valid;
        wmem_d   = d_wmem & d_valid;
        aluimm_d = d_aluimm;
        shift_d  = d_shift;
        jal_d    = d_jal;
        pc8_d    = d_pc4 + DW'(4);
    end

    // ID/EX register: reset and flush both empty the slot, stall holds it
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_q  <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            sa_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            wn_q     <= '0;
            aluc_q   <= '0;
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            aluimm_q <= 1'b0;
            shift_q  <= 1'b0;
            jal_q    <= 1'b0;
            pc8_q    <= '0;
        end else if (!stall) begin
            valid_q  <= valid_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            imm_q    <= imm_d;
            sa_q     <= sa_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wn_q     <= wn_d;
            aluc_q   <= aluc_d;
            wreg_q   <= wreg_d;
            m2reg_q  <= m2reg_d;
            wmem_q   <= wmem_d;
            aluimm_q <= aluimm_d;
            shift_q  <= shift_d;
            jal_q    <= jal_d;
            pc8_q    <= pc8_d;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src_i     (rs_q),
        .reg_i     (ra_q),
        .m_wreg_i  (m_wreg),
        .m_m2reg_i (m_m2reg),
        .m_wn_i    (m_wn),
        .m_alu_i   (m_alu),
        .w_wreg_i  (w_wreg),
        .w_wn_i    (w_wn),
        .w_data_i  (w_data),
        .val_o     (fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src_i     (rt_q),
        .reg_i     (rb_q),
        .m_wreg_i  (m_wreg),
        .m_m2reg_i (m_m2reg),
        .m_wn_i    (m_wn),
        .m_alu_i   (m_alu),
        .w_wreg_i  (w_wreg),
        .w_wn_i    (w_wn),
        .w_data_i  (w_data),
        .val_o     (fwd_rt)
    );

    // Operand select and load-use check; only sources the instruction actually reads can hazard
    always_comb begin
        rs_used  = ~shift_q;
        rt_used  = ~aluimm_q | wmem_q;
        e_alu_a  = shift_q ? {{(DW-5){1'b0}}, sa_q} : fwd_rs;
        e_alu_b  = aluimm_q ? imm_q : fwd_rt;
        e_store  = fwd_rt;
        e_hazard = valid_q & m_m2reg & m_wreg & (m_wn != '0) &
                   (((m_wn == rs_q) & rs_used) | ((m_wn == rt_q) & rt_used));
    end

    assign e_aluc  = aluc_q;
    assign e_wn    = wn_q;
    assign e_wreg  = wreg_q;
    assign e_m2reg = m2reg_q;
    assign e_wmem  = wmem_q;
    assign e_jal   = jal_q;
    assign e_pc8   = pc8_q;
    assign e_valid = valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for the ID/EX operand stage
module tb_ex_operand_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        d_valid;
    logic [31:0] d_ra, d_rb, d_pc4;
    logic [15:0] d_imm;
    logic [4:0]  d_sa, d_rs, d_rt, d_wn;
    logic [3:0]  d_aluc;
    logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_sext, d_jal;
    logic        m_wreg, m_m2reg, w_wreg;
    logic [4:0]  m_wn, w_wn;
    logic [31:0] m_alu, w_data;
    logic [31:0] e_alu_a, e_alu_b, e_store, e_pc8;
    logic [3:0]  e_aluc;
    logic [4:0]  e_wn;
    logic        e_wreg, e_m2reg, e_wmem, e_jal, e_valid, e_hazard;

    ex_operand_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_ra(d_ra), .d_rb(d_rb), .d_imm(d_imm), .d_sa(d_sa),
        .d_rs(d_rs), .d_rt(d_rt), .d_wn(d_wn), .d_aluc(d_aluc),
        .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_aluimm(d_aluimm),
        .d_shift(d_shift), .d_sext(d_sext), .d_jal(d_jal), .d_pc4(d_pc4),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wn(m_wn), .m_alu(m_alu),
        .w_wreg(w_wreg), .w_wn(w_wn), .w_data(w_data),
        .e_alu_a(e_alu_a), .e_alu_b(e_alu_b), .e_aluc(e_aluc), .e_store(e_store),
        .e_wn(e_wn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
        .e_jal(e_jal), .e_pc8(e_pc8), .e_valid(e_valid), .e_hazard(e_hazard)
    );

    always #5 clock = ~clock;

    typedef enum int {F_A, F_B, F_STORE, F_ALUC, F_WN, F_WREG, F_M2REG, F_WMEM,
                      F_JAL, F_PC8, F_VALID, F_HAZ} fld_t;
    typedef struct {
        string       name;
        fld_t        f;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [31:0] actual(input fld_t f);
        case (f)
            F_A:     return e_alu_a;
            F_B:     return e_alu_b;
            F_STORE: return e_store;
            F_ALUC:  return {28'd0, e_aluc};
            F_WN:    return {27'd0, e_wn};
            F_WREG:  return {31'd0, e_wreg};
            F_M2REG: return {31'd0, e_m2reg};
            F_WMEM:  return {31'd0, e_wmem};
            F_JAL:   return {31'd0, e_jal};
            F_PC8:   return e_pc8;
            F_VALID: return {31'd0, e_valid};
            default: return {31'd0, e_hazard};
        endcase
    endfunction

    // Monitor: drain every expectation queued since the last rising edge
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            sb_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = actual(e.f);
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string nm, input fld_t f, input logic [31:0] v);
        sb.push_back('{nm, f, v});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_d();
        d_valid = 0; d_ra = 0; d_rb = 0; d_imm = 0; d_sa = 0; d_rs = 0; d_rt = 0;
        d_wn = 0; d_aluc = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0;
        d_shift = 0; d_sext = 0; d_jal = 0; d_pc4 = 0;
    endtask

    task automatic rand_d();
        d_valid = 1'($urandom); d_ra = $urandom; d_rb = $urandom; d_imm = 16'($urandom);
        d_sa = 5'($urandom); d_rs = 5'($urandom); d_rt = 5'($urandom); d_wn = 5'($urandom);
        d_aluc = 4'($urandom); d_wreg = 1'($urandom); d_m2reg = 1'($urandom);
        d_wmem = 1'($urandom); d_aluimm = 1'($urandom); d_shift = 1'($urandom);
        d_sext = 1'($urandom); d_jal = 1'($urandom); d_pc4 = $urandom;
    endtask

    task automatic clear_fwd();
        m_wreg = 0; m_m2reg = 0; m_wn = 0; m_alu = 0; w_wreg = 0; w_wn = 0; w_data = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; stall = 0; flush = 0;
        clear_fwd();
        rand_d(); step();
        rand_d(); step();
        chk("rst_valid", F_VALID, 0); chk("rst_wreg", F_WREG, 0);
        chk("rst_m2reg", F_M2REG, 0); chk("rst_wmem", F_WMEM, 0);
        chk("rst_jal", F_JAL, 0);     chk("rst_aluc", F_ALUC, 0);
        chk("rst_wn", F_WN, 0);       chk("rst_pc8", F_PC8, 0);
        chk("rst_a", F_A, 0);         chk("rst_b", F_B, 0);
        chk("rst_store", F_STORE, 0); chk("rst_haz", F_HAZ, 0);

        reset = 0;
        clear_d(); d_valid = 1; d_aluc = 4'b0111;
        step();
        chk("load_aluc", F_ALUC, 32'h7); chk("load_valid", F_VALID, 1);

        // Forwarding priority
        clear_d(); d_valid = 1; d_rs = 3; d_ra = 5; d_rt = 6; d_rb = 32'h66;
        step();
        clear_fwd(); m_wreg = 1; m_wn = 3; m_alu = 32'h1234;
        chk("mem_fwd_a", F_A, 32'h1234); chk("mem_fwd_store_nohit", F_STORE, 32'h66);
        step();
        w_wreg = 1; w_wn = 3; w_data = 32'h9;
        chk("mem_over_wb", F_A, 32'h1234);
        step();
        m_wn = 0;
        chk("wb_fwd_a", F_A, 32'h9);
        step();
        m_wn = 3; m_m2reg = 1;
        chk("load_no_mem_fwd", F_A, 32'h9); chk("rs_load_haz", F_HAZ, 1);
        step();
        clear_fwd(); w_wreg = 1; w_wn = 6; w_data = 32'h77;
        chk("wb_fwd_store", F_STORE, 32'h77); chk("reg_a", F_A, 32'h5);
        d_rs = 0;
        step();
        clear_fwd(); m_wreg = 1; m_wn = 0; m_alu = 32'h1234; w_wreg = 1; w_wn = 0; w_data = 32'h9;
        chk("r0_no_fwd", F_A, 32'h5);

        // Immediate and shift
        clear_d(); d_valid = 1; d_imm = 16'h8001; d_sext = 1; d_aluimm = 1;
        step();
        clear_fwd();
        chk("imm_sext", F_B, 32'hFFFF8001);
        d_sext = 0;
        step();
        chk("imm_zext", F_B, 32'h00008001);
        d_shift = 1; d_sa = 7; d_ra = 32'h55;
        step();
        chk("shift_a", F_A, 32'h7);
        d_shift = 0; d_aluimm = 0; d_rt = 2; d_rb = 32'hBEEF;
        step();
        chk("rt_b", F_B, 32'hBEEF); chk("ra_a", F_A, 32'h55);

        // Load-use
        clear_d(); d_valid = 1; d_rt = 4; d_rb = 32'h44;
        step();
        clear_fwd(); m_m2reg = 1; m_wreg = 1; m_wn = 4; m_alu = 32'hDEAD;
        chk("lu_rt", F_HAZ, 1); chk("lu_store_reg", F_STORE, 32'h44);
        d_aluimm = 1;
        step();
        chk("lu_rt_unused", F_HAZ, 0);
        d_wmem = 1;
        step();
        chk("lu_store_used", F_HAZ, 1);
        clear_d(); d_valid = 1; d_rs = 4;
        step();
        chk("lu_rs", F_HAZ, 1);
        d_shift = 1;
        step();
        chk("lu_rs_shift", F_HAZ, 0);
        d_shift = 0; d_valid = 0;
        step();
        chk("lu_invalid", F_HAZ, 0); chk("invalid_valid", F_VALID, 0);
        d_valid = 1; d_rs = 0; d_rt = 0;
        step();
        m_wn = 0;
        chk("lu_r0", F_HAZ, 0);

        // Stall and flush
        clear_d(); d_valid = 1; d_aluc = 5; d_wreg = 1; d_wmem = 1; d_rs = 1; d_ra = 32'hAAAA;
        step();
        clear_fwd();
        chk("pre_stall_aluc", F_ALUC, 32'h5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step();
            chk("stall_aluc", F_ALUC, 32'h5); chk("stall_a", F_A, 32'hAAAA);
            chk("stall_valid", F_VALID, 1);   chk("stall_wreg", F_WREG, 1);
            chk("stall_wmem", F_WMEM, 1);
        end
        flush = 1;
        step();
        chk("flush_valid", F_VALID, 0); chk("flush_wreg", F_WREG, 0);
        chk("flush_wmem", F_WMEM, 0);   chk("flush_aluc", F_ALUC, 0);
        flush = 0; stall = 0;
        clear_d(); d_valid = 1; d_wreg = 1; d_aluc = 3;
        step();
        chk("reload_valid", F_VALID, 1);
        flush = 1;
        step();
        chk("flush_only_valid", F_VALID, 0);
        flush = 0;
        step();
        chk("reload2_aluc", F_ALUC, 32'h3);

        // Reset while stalled
        stall = 1; reset = 1;
        step();
        chk("rst_stall_valid", F_VALID, 0); chk("rst_stall_aluc", F_ALUC, 0);
        reset = 0;
        step();
        chk("post_rst_valid", F_VALID, 0); chk("post_rst_wreg", F_WREG, 0);
        stall = 0;

        // jal link and pc+8
        clear_d(); d_valid = 1; d_jal = 1; d_wreg = 1; d_wn = 5; d_pc4 = 32'h00400004;
        step();
        chk("jal_pc8", F_PC8, 32'h00400008); chk("jal_wn", F_WN, 32'd31);
        chk("jal_flag", F_JAL, 1);
        d_pc4 = 32'hFFFFFFFC;
        step();
        chk("pc8_wrap", F_PC8, 32'h0);
        d_jal = 0;
        step();
        chk("nojal_wn", F_WN, 32'd5); chk("nojal_flag", F_JAL, 0);

        step();
        step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection for the pipelined computer.
- Captures decoded fields and register-file reads from ID and applies forwarding from EX/MEM and MEM/WB.
- Drives the ALU's a, b and aluc inputs directly, plus the control and store data passed on to EX/MEM.
- Also detects the load-use hazard the forwarding network cannot resolve.

Parameters:
- DW, 32, datapath width; the ALU is fixed at 32, so only 32 is supported.
- RW, 5, register-number width.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all ID/EX state this cycle.
- flush  in  1  load a bubble this cycle.
- d_valid  in  1  ID instruction valid.
- d_ra  in  DW  register-file read data for rs.
- d_rb  in  DW  register-file read data for rt.
- d_imm  in  16  instruction immediate.
- d_sa  in  5  shift amount.
- d_rs  in  RW  source register number, rs.
- d_rt  in  RW  source register number, rt.
- d_wn  in  RW  destination register number.
- d_aluc  in  4  ALU opcode.
- d_wreg  in  1  control bit: write register.
- d_m2reg  in  1  control bit: load (memory to register).
- d_wmem  in  1  control bit: write memory.
- d_aluimm  in  1  control bit: use immediate as ALU b.
- d_shift  in  1  control bit: use shift amount as ALU a.
- d_sext  in  1  control bit: sign-extend immediate.
- d_jal  in  1  control bit: jump-and-link.
- d_pc4  in  DW  PC+4 of the ID instruction.
- m_wreg  in  1  EX/MEM instruction writes a register.
- m_m2reg  in  1  EX/MEM instruction is a load.
- m_wn  in  RW  EX/MEM destination register.
- m_alu  in  DW  EX/MEM ALU result.
- w_wreg  in  1  MEM/WB instruction writes a register.
- w_wn  in  RW  MEM/WB destination register.
- w_data  in  DW  MEM/WB write-back data.
- e_alu_a  out  DW  ALU operand a.
- e_alu_b  out  DW  ALU operand b.
- e_aluc  out  4  ALU opcode.
- e_store  out  DW  forwarded rt value used as store data.
- e_wn  out  RW  destination register; 31 when jal.
- e_wreg  out  1  registered control, gated by valid.
- e_m2reg  out  1  registered control, gated by valid.
- e_wmem  out  1  registered control, gated by valid.
- e_jal  out  1  registered jal flag.
- e_pc8  out  DW  registered PC+4, plus 4.
- e_valid  out  1  EX slot holds a real instruction.
- e_hazard  out  1  load-use hazard; request to the hazard unit to stall ID and flush this stage.

Behaviour:
- Update priority each edge: reset > flush > stall > load.
  - reset: every register is 0, so all outputs are 0 except e_alu_a/e_alu_b/e_store, which are combinational and read 0 with zero operands; e_hazard=0.
  - flush: valid, wreg, m2reg, wmem and jal are cleared; data registers are don't-care but shall be cleared to 0.
  - stall without flush: all registers hold.
  - otherwise: all d_* inputs are captured; valid<=d_valid.
- Registered immediate extension:
  - d_sext=1: imm is sign-extended to 32 bits.
  - d_sext=0: imm is zero-extended.
- Destination register: jal forces e_wn=31.
- Forwarding, combinational on the registered rs/rt (call each src):
  - Source is m_alu when m_wreg & !m_m2reg & m_wn==src & src!=0.
  - Else source is w_data when w_wreg & w_wn==src & src!=0.
  - Else the registered register-file value.
  - MEM beats WB; register 0 is never forwarded.
- Operand selection:
  - e_alu_a = d_shift ? {27'b0, sa} : fwd_rs.
  - e_alu_b = aluimm ? ext_imm : fwd_rt.
  - e_store = fwd_rt.
- Hazard:
  - e_hazard = e_valid & m_m2reg & m_wreg & m_wn!=0 & (m_wn==rs_used | m_wn==rt_used).
  - rs_used = !shift.
  - rt_used = !aluimm | wmem.
  - e_hazard is combinational.
  - While hazard is asserted the EX/MEM register must capture a bubble; this block holds when stall=1.
- jal: e_pc8 = pc4+4, with 32-bit wrap (0xFFFFFFFC+4 -> 0x00000000).
- Reset mid-stall clears state; after deassert the stage is empty until the next load.
- Outputs are driven only from registers and the forward inputs; there is no combinational path from d_* to e_*.

Decomposition:
- Shared package pipe_pkg: ALUC encodings (ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111), REG_RA=31, widths.
- One sub-module, fwd_mux: 2-level source select, instanced once for rs and once for rt.

Test Plan:
- Reset: reset=1 with random d_* for 2 cycles -> all e_* =0 and e_valid=0; after deassert with load, e_aluc matches d_aluc next cycle.
- MEM forwarding:
  - Stimulus: captured rs=3, d_ra=5; m_wreg=1, m_wn=3, m_alu=0x1234.
  - Response: e_alu_a=0x1234.
  - Add w_wn=3, w_data=0x9 -> still 0x1234 (MEM priority).
  - Set m_wn=0, rs=0 -> e_alu_a=d_ra.
- Immediate and shift:
  - d_imm=0x8001, sext=1, aluimm=1 -> e_alu_b=0xFFFF8001.
  - sext=0 -> 0x00008001.
  - shift=1, sa=7 -> e_alu_a=7.
- Load-use:
  - Stimulus: e_valid, rt=4 used; m_m2reg=m_wreg=1, m_wn=4.
  - Response: e_hazard=1.
  - With aluimm=1, wmem=0 -> e_hazard=0.
- Stall/flush:
  - stall=1 for 3 cycles with changing d_* -> outputs frozen.
  - stall=1 & flush=1 -> e_valid=0, e_wreg=0, e_wmem=0 next cycle.
- jal: d_jal=1, d_pc4=0x00400004 -> e_pc8=0x00400008, e_wn=31; d_pc4=0xFFFFFFFC -> e_pc8=0.
